// File: rtl/ship_shot_ctrl.sv
// ship_shot_ctrl: player-shot manager for a fixed pool of shot slots.
// Once per frame it moves every active shot upward, retires shots that would
// leave the top of the screen, then spawns at most one new shot above the ship.
// It also reports, one clock later, whether the pixel being drawn lies inside
// a shot and where in the 3x8 sprite it falls.
//
// Build option: define SHIP_SHOT_AUTOFIRE_EN so that a held fire key re-fires
// every COOLDOWN+1 frames. Left undefined, only a 0->1 fire edge requests a shot.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   frame_tick_i            one-cycle pulse per video frame
//   fire_i                  fire key level
//   ship_x_i, ship_y_i      ship top-left pixel
//   draw_x_i, draw_y_i      pixel currently being drawn
//   hit_valid_i, hit_slot_i collision logic kills slot hit_slot_i
//   is_shot_o               registered: draw pixel is inside an active shot
//   sprite_x_o, sprite_y_o  registered sprite column/row of that pixel
//   shot_fired_o            one-cycle pulse when a shot spawns
//   busy_o                  frame update in progress
//   active_mask_o           per-slot active flags
module ship_shot_ctrl #(
   parameter int unsigned MAX_SHOTS  = 2,
   parameter int unsigned SHOT_SPEED = 4,
   parameter int unsigned COOLDOWN   = 3,
   parameter int unsigned X_OFFSET   = 6
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 frame_tick_i,
   input  logic                 fire_i,
   input  logic [9:0]           ship_x_i,
   input  logic [9:0]           ship_y_i,
   input  logic [9:0]           draw_x_i,
   input  logic [9:0]           draw_y_i,
   input  logic                 hit_valid_i,
   input  logic [1:0]           hit_slot_i,
   output logic                 is_shot_o,
   output logic [9:0]           sprite_x_o,
   output logic [9:0]           sprite_y_o,
   output logic                 shot_fired_o,
   output logic                 busy_o,
   output logic [MAX_SHOTS-1:0] active_mask_o
);

   typedef enum logic [1:0] {StIdle, StMove, StSpawn} state_e;

   state_e               state_q, state_d;
   logic [1:0]           slot_idx_q, slot_idx_d;
   logic                 pending_q, pending_d;
   logic [3:0]           cooldown_q, cooldown_d;
   logic                 cd_ok_q, cd_ok_d;
   logic [MAX_SHOTS-1:0] active_q, active_d;
   logic [9:0]           x_q [MAX_SHOTS];
   logic [9:0]           x_d [MAX_SHOTS];
   logic [9:0]           y_q [MAX_SHOTS];
   logic [9:0]           y_d [MAX_SHOTS];
   logic                 shot_fired_d, shot_fired_q;
   logic                 is_shot_d, is_shot_q;
   logic [9:0]           sprite_x_d, sprite_x_q;
   logic [9:0]           sprite_y_d, sprite_y_q;
   logic                 fire_set;
   logic                 free_found;

`ifdef SHIP_SHOT_AUTOFIRE_EN
   // Level-sensitive: fire held at an accepted frame tick requests a shot.
   assign fire_set = fire_i && frame_tick_i && (state_q == StIdle);
`else
   logic fire_q;

   assign fire_set = fire_i && !fire_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fire_q <= 1'b0;
      end else begin
         fire_q <= fire_i;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      slot_idx_d   = slot_idx_q;
      pending_d    = pending_q;
      cooldown_d   = cooldown_q;
      cd_ok_d      = cd_ok_q;
      active_d     = active_q;
      x_d          = x_q;
      y_d          = y_q;
      shot_fired_d = 1'b0;
      free_found   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (frame_tick_i) begin
               state_d    = StMove;
               slot_idx_d = 2'd0;
               // Spawn permission is judged on the count at frame start, so
               // COOLDOWN whole frames are blocked after each spawn.
               cd_ok_d    = (cooldown_q == 4'd0);
               if (cooldown_q != 4'd0) cooldown_d = cooldown_q - 4'd1;
            end
         end
         StMove: begin
            for (int i = 0; i < int'(MAX_SHOTS); i++) begin
               if (slot_idx_q == 2'(i) && active_q[i]) begin
                  if (y_q[i] >= 10'(SHOT_SPEED)) y_d[i] = y_q[i] - 10'(SHOT_SPEED);
                  else                           active_d[i] = 1'b0;
               end
            end
            if (slot_idx_q == 2'(MAX_SHOTS - 1)) state_d = StSpawn;
            else                                  slot_idx_d = slot_idx_q + 2'd1;
         end
         StSpawn: begin
            state_d   = StIdle;
            pending_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // Applied after the move step so a kill overrides a simultaneous move.
      for (int i = 0; i < int'(MAX_SHOTS); i++) begin
         if (hit_valid_i && hit_slot_i == 2'(i)) active_d[i] = 1'b0;
      end

      // Applied last so a spawn overrides a simultaneous kill of the same slot.
      if (state_q == StSpawn && pending_q && cd_ok_q && ship_y_i >= 10'd8) begin
         for (int i = 0; i < int'(MAX_SHOTS); i++) begin
            if (!free_found && !active_q[i]) begin
               free_found   = 1'b1;
               active_d[i]  = 1'b1;
               x_d[i]       = ship_x_i + 10'(X_OFFSET);
               y_d[i]       = ship_y_i - 10'd8;
               shot_fired_d = 1'b1;
               cooldown_d   = 4'(COOLDOWN);
            end
         end
      end

      if (fire_set) pending_d = 1'b1;
   end

   // Pixel lookup; descending scan so the lowest matching slot is kept.
   always_comb begin
      is_shot_d  = 1'b0;
      sprite_x_d = 10'd0;
      sprite_y_d = 10'd0;
      for (int i = int'(MAX_SHOTS) - 1; i >= 0; i--) begin
         if (active_q[i] && draw_x_i >= x_q[i] && draw_y_i >= y_q[i] &&
             (draw_x_i - x_q[i]) <= 10'd2 && (draw_y_i - y_q[i]) <= 10'd7) begin
            is_shot_d  = 1'b1;
            sprite_x_d = draw_x_i - x_q[i];
            sprite_y_d = draw_y_i - y_q[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         slot_idx_q   <= 2'd0;
         pending_q    <= 1'b0;
         cooldown_q   <= 4'd0;
         cd_ok_q      <= 1'b0;
         active_q     <= '0;
         shot_fired_q <= 1'b0;
         is_shot_q    <= 1'b0;
         sprite_x_q   <= 10'd0;
         sprite_y_q   <= 10'd0;
         for (int i = 0; i < int'(MAX_SHOTS); i++) begin
            x_q[i] <= 10'd0;
            y_q[i] <= 10'd0;
         end
      end else begin
         state_q      <= state_d;
         slot_idx_q   <= slot_idx_d;
         pending_q    <= pending_d;
         cooldown_q   <= cooldown_d;
         cd_ok_q      <= cd_ok_d;
         active_q     <= active_d;
         shot_fired_q <= shot_fired_d;
         is_shot_q    <= is_shot_d;
         sprite_x_q   <= sprite_x_d;
         sprite_y_q   <= sprite_y_d;
         for (int i = 0; i < int'(MAX_SHOTS); i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   assign is_shot_o     = is_shot_q;
   assign sprite_x_o    = sprite_x_q;
   assign sprite_y_o    = sprite_y_q;
   assign shot_fired_o  = shot_fired_q;
   assign busy_o        = (state_q != StIdle);
   assign active_mask_o = active_q;

endmodule

// File: tb/tb_ship_shot_ctrl.sv
// Directed bench for ship_shot_ctrl with MAX_SHOTS=2, SHOT_SPEED=4, COOLDOWN=3,
// X_OFFSET=6 in the default (edge-triggered fire) build. Shot positions are
// observed through the draw-lookup outputs.
module tb_ship_shot_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       fire = 1'b0;
   logic [9:0] ship_x = 10'd0;
   logic [9:0] ship_y = 10'd0;
   logic [9:0] draw_x = 10'd0;
   logic [9:0] draw_y = 10'd0;
   logic       hit_valid = 1'b0;
   logic [1:0] hit_slot = 2'd0;
   logic       is_shot;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic       shot_fired;
   logic       busy;
   logic [1:0] active_mask;

   int tests = 0;
   int fails = 0;
   int fired;
   int total;

   ship_shot_ctrl #(
      .MAX_SHOTS (2),
      .SHOT_SPEED(4),
      .COOLDOWN  (3),
      .X_OFFSET  (6)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .frame_tick_i (frame_tick),
      .fire_i       (fire),
      .ship_x_i     (ship_x),
      .ship_y_i     (ship_y),
      .draw_x_i     (draw_x),
      .draw_y_i     (draw_y),
      .hit_valid_i  (hit_valid),
      .hit_slot_i   (hit_slot),
      .is_shot_o    (is_shot),
      .sprite_x_o   (sprite_x),
      .sprite_y_o   (sprite_y),
      .shot_fired_o (shot_fired),
      .busy_o       (busy),
      .active_mask_o(active_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fire();
      fire = 1'b1;
      step();
      fire = 1'b0;
   endtask

   // One full frame update; returns the number of shot_fired pulses seen.
   task automatic do_frame(output int n);
      n = 0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (shot_fired) n++;
         if (!busy) break;
         step();
      end
      chk("frame_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py,
                        input logic eh, input logic [9:0] ex, input logic [9:0] ey);
      draw_x = px;
      draw_y = py;
      step();
      chk({tag, "_hit"}, {31'd0, is_shot}, {31'd0, eh});
      chk({tag, "_sx"}, {22'd0, sprite_x}, {22'd0, ex});
      chk({tag, "_sy"}, {22'd0, sprite_y}, {22'd0, ey});
   endtask

   task automatic hit(input logic [1:0] s);
      hit_valid = 1'b1;
      hit_slot  = s;
      step();
      hit_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mask", {30'd0, active_mask}, 32'd0);
      chk("rst_fired", {31'd0, shot_fired}, 32'd0);
      probe("rst_draw", 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);

      // First shot: (100,400) -> slot0 at (106,392)
      ship_x = 10'd100;
      ship_y = 10'd400;
      pulse_fire();
      do_frame(fired);
      chk("spawn1_fired", fired, 1);
      chk("spawn1_mask", {30'd0, active_mask}, 32'd1);
      probe("s0_origin", 10'd106, 10'd392, 1'b1, 10'd0, 10'd0);
      probe("s0_inner", 10'd108, 10'd395, 1'b1, 10'd2, 10'd3);
      probe("s0_right", 10'd109, 10'd395, 1'b0, 10'd0, 10'd0);
      probe("s0_left", 10'd105, 10'd392, 1'b0, 10'd0, 10'd0);
      probe("s0_above", 10'd106, 10'd391, 1'b0, 10'd0, 10'd0);
      probe("s0_bottom", 10'd106, 10'd399, 1'b1, 10'd0, 10'd7);

      // Next frame: moves to 388, no spawn
      do_frame(fired);
      chk("move_fired", fired, 0);
      probe("s0_moved", 10'd106, 10'd388, 1'b1, 10'd0, 10'd0);
      probe("s0_moved_up", 10'd106, 10'd387, 1'b0, 10'd0, 10'd0);

      // Fire during cooldown is dropped; later frames do not re-fire
      pulse_fire();
      do_frame(fired);
      chk("cool_a", fired, 0);
      do_frame(fired);
      chk("cool_b", fired, 0);
      do_frame(fired);
      chk("dropped", fired, 0);
      chk("dropped_mask", {30'd0, active_mask}, 32'd1);

      // Second shot into slot1 at (206,292); slot0 now at 372
      ship_x = 10'd200;
      ship_y = 10'd300;
      pulse_fire();
      do_frame(fired);
      chk("spawn2_fired", fired, 1);
      chk("spawn2_mask", {30'd0, active_mask}, 32'd3);
      probe("s1_origin", 10'd206, 10'd292, 1'b1, 10'd0, 10'd0);
      probe("s0_at372", 10'd106, 10'd372, 1'b1, 10'd0, 10'd0);

      // Let cooldown expire, then a third fire with both slots full
      repeat (4) do_frame(fired);
      pulse_fire();
      do_frame(fired);
      chk("full_fired", fired, 0);
      chk("full_mask", {30'd0, active_mask}, 32'd3);
      do_frame(fired);
      chk("full_pending_clr", fired, 0);
      probe("s1_at268", 10'd206, 10'd268, 1'b1, 10'd0, 10'd0);

      // Hits while idle
      hit(2'd1);
      chk("hit1_mask", {30'd0, active_mask}, 32'd1);
      hit(2'd3);
      chk("hit_oor_mask", {30'd0, active_mask}, 32'd1);
      hit(2'd1);
      chk("hit_inact_mask", {30'd0, active_mask}, 32'd1);

      // Hit slot0 in the cycle MOVE processes it
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("move_busy", {31'd0, busy}, 32'd1);
      hit(2'd0);
      repeat (3) step();
      chk("hit_move_busy", {31'd0, busy}, 32'd0);
      chk("hit_move_mask", {30'd0, active_mask}, 32'd0);

      // Retire near the top: y=7 -> 3 -> inactive, no wrap
      ship_x = 10'd50;
      ship_y = 10'd15;
      pulse_fire();
      do_frame(fired);
      chk("top_fired", fired, 1);
      probe("top_y7", 10'd56, 10'd7, 1'b1, 10'd0, 10'd0);
      do_frame(fired);
      probe("top_y3", 10'd56, 10'd3, 1'b1, 10'd0, 10'd0);
      do_frame(fired);
      chk("top_mask", {30'd0, active_mask}, 32'd0);
      probe("top_nowrap", 10'd56, 10'd1023, 1'b0, 10'd0, 10'd0);

      // ShipY < 8 drops the request once cooldown has expired
      repeat (2) do_frame(fired);
      ship_y = 10'd7;
      pulse_fire();
      do_frame(fired);
      chk("lowy_fired", fired, 0);
      chk("lowy_mask", {30'd0, active_mask}, 32'd0);
      ship_x = 10'd100;
      ship_y = 10'd400;
      pulse_fire();
      do_frame(fired);
      chk("re_fired", fired, 1);
      chk("re_mask", {30'd0, active_mask}, 32'd1);

      // Overlapping shots: slot0 (106,376), slot1 (107,378); lowest index wins
      repeat (3) do_frame(fired);
      ship_x = 10'd101;
      ship_y = 10'd386;
      pulse_fire();
      do_frame(fired);
      chk("ovl_fired", fired, 1);
      probe("ovl_both", 10'd107, 10'd379, 1'b1, 10'd1, 10'd3);
      probe("ovl_s1only", 10'd109, 10'd385, 1'b1, 10'd2, 10'd7);

      // Reset mid-MOVE aborts the update and clears everything
      hit(2'd1);
      pulse_fire();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_mask", {30'd0, active_mask}, 32'd0);
      chk("mid_rst_fired", {31'd0, shot_fired}, 32'd0);
      do_frame(fired);
      chk("mid_rst_nopend", fired, 0);

      // Fire held for 10 frames: exactly one shot
      ship_x = 10'd100;
      ship_y = 10'd400;
      fire = 1'b1;
      total = 0;
      for (int f = 0; f < 10; f++) begin
         do_frame(fired);
         total += fired;
      end
      fire = 1'b0;
      chk("held_total", total, 1);
      step();

      // Hit on the slot SPAWN fills in the same cycle: spawn wins
      pulse_fire();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      hit(2'd1);
      chk("spawn_vs_hit_fired", {31'd0, shot_fired}, 32'd1);
      chk("spawn_vs_hit_mask", {30'd0, active_mask}, 32'd3);
      chk("spawn_vs_hit_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ship_shot_ctrl.md
SHIP_SHOT_CTRL -- requirements
Module: ship_shot_ctrl

Interface
REQ-001 Parameter MAX_SHOTS, default 2: number of player-shot slots, 1..4.
REQ-002 Parameter SHOT_SPEED, default 4: pixels moved upward per frame, 1..15.
REQ-003 Parameter COOLDOWN, default 3: frames after a spawn during which no new spawn is accepted, 0..15.
REQ-004 Parameter X_OFFSET, default 6: shot X = ShipX + X_OFFSET.
REQ-005 Clk  in  1  sole clock; all logic rising-edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_tick  in  1  one-Clk pulse per video frame.
REQ-008 fire  in  1  fire key level.
REQ-009 ShipX, ShipY  in  10 each  ship top-left pixel position.
REQ-010 DrawX, DrawY  in  10 each  current pixel being drawn.
REQ-011 hit_valid  in  1  enemy-collision logic kills a shot this cycle.
REQ-012 hit_slot  in  2  slot index killed when hit_valid=1.
REQ-013 is_shot  out  1  registered: (DrawX,DrawY) lies inside an active shot.
REQ-014 SpriteX, SpriteY  out  10 each  registered column 0..2 / row 0..7 within the 3x8 shot sprite for the ROM.
REQ-015 shot_fired  out  1  one-Clk pulse when a shot spawns.
REQ-016 busy  out  1  high while the frame-update FSM is not IDLE.
REQ-017 active_mask  out  MAX_SHOTS  per-slot active flags.

Function
REQ-018 Each slot SHALL hold active, x[9:0], y[9:0].
REQ-019 Fire request SHALL be latched into a pending flag on a qualifying fire event (see Configuration) and held until the next frame update consumes or drops it.
REQ-020 FSM states IDLE, MOVE, SPAWN; IDLE->MOVE on frame_tick; MOVE processes one slot per cycle, slot 0 first, for MAX_SHOTS cycles; MOVE->SPAWN; SPAWN->IDLE after one cycle.
REQ-021 frame_tick while not IDLE SHALL be ignored.
REQ-022 MOVE: active slot with y >= SHOT_SPEED gets y -= SHOT_SPEED; active slot with y < SHOT_SPEED becomes inactive (no wrap-around).
REQ-023 Cooldown counter SHALL decrement by one on entering MOVE when nonzero.
REQ-024 SPAWN: if pending, cooldown==0, a free slot exists and ShipY >= 8, lowest-index free slot gets active=1, x=ShipX+X_OFFSET (10-bit, wrap ignored), y=ShipY-8; shot_fired pulses; cooldown loads COOLDOWN.
REQ-025 SPAWN SHALL clear pending whether or not a shot spawned (all slots full, cooldown, ShipY<8 drop the request).
REQ-026 A spawned shot SHALL NOT move in the frame it spawns.
REQ-027 hit_valid with active hit_slot SHALL clear that slot next edge in any state; hit on inactive or out-of-range slot ignored.
REQ-028 hit_valid on the slot MOVE is processing in the same cycle: clear wins, slot ends inactive.
REQ-029 hit_valid on a slot in the same cycle SPAWN fills it: spawn wins.
REQ-030 Draw: slot hits when x<=DrawX<=x+2 and y<=DrawY<=y+7; is_shot, SpriteX=DrawX-x, SpriteY=DrawY-y registered one Clk after DrawX/DrawY; lowest index wins on overlap; no hit -> is_shot=0, SpriteX=SpriteY=0.

Reset
REQ-031 Reset SHALL force: all slots inactive, x=y=0, FSM IDLE, pending=0, cooldown=0, fire-edge history=0, is_shot=0, SpriteX=SpriteY=0, shot_fired=0, busy=0.
REQ-032 Reset mid-MOVE or mid-SPAWN SHALL abort the update with no spawn and no shot_fired.

Configuration
REQ-033 Macro SHIP_SHOT_AUTOFIRE_EN defined: fire level high at frame_tick sets pending, so held fire re-fires every COOLDOWN+1 frames.
REQ-034 Macro absent: only a 0->1 edge of fire (registered history) sets pending; holding fire yields exactly one shot.

Verification (MAX_SHOTS=2, SHOT_SPEED=4, COOLDOWN=3, X_OFFSET=6)
REQ-035 ShipX=100, ShipY=400, fire pulse, frame_tick -> shot_fired once; slot0 x=106 y=392; next frame_tick y=388.
REQ-036 Slot0 at y=3, frame_tick -> slot0 inactive, active_mask=0, no wrap to 1023.
REQ-037 Two spawned shots, third fire edge after cooldown expires -> no shot_fired, pending cleared, active_mask=2'b11.
REQ-038 DrawX=108, DrawY=395 with slot0 at (106,392) -> next Clk is_shot=1, SpriteX=2, SpriteY=3; DrawX=109 -> is_shot=0.
REQ-039 hit_valid, hit_slot=0 in the cycle MOVE processes slot0 -> slot0 inactive afterward.
REQ-040 Fire held high 10 frames: without SHIP_SHOT_AUTOFIRE_EN exactly 1 shot_fired; with it, shots on frames 1, 5, 9 (slots freed by hits).
